// File: rtl/legal_move_arbiter.sv
// Round-robin arbiter sharing the single-ported legal-move table among Pacman and the ghosts.
// Optional PACMAN_PRIORITY_EN: requester 0 always wins and does not advance the pointer.
module legal_move_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int GRID_W  = 8,
  parameter int GRID_H  = 8,
  parameter int ID_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*3-1:0] req_x_i,
  input  logic [NUM_REQ*3-1:0] req_y_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [5:0]           tbl_addr_o,
  input  logic [3:0]           tbl_data_i,
  output logic                 rsp_valid_o,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [3:0]           rsp_moves_o,
  output logic                 rsp_oob_o,
  output logic [ID_W-1:0]      dbg_ptr_o
);

  // Handshake: gnt_o[i] is a combinational pulse in the cycle req_i[i] wins; the
  // coordinates are sampled on the edge ending that cycle, and exactly one response
  // (rsp_valid_o, no backpressure) follows two cycles later in grant order.

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand_idx;
  int              cand;
  logic [2:0]      sel_x, sel_y;
  logic            oob;
  int              addr_full;
  logic [5:0]      addr_d;

  logic            s1_valid_q;
  logic [ID_W-1:0] s1_id_q;
  logic            s1_oob_q;
  logic [5:0]      tbl_addr_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [3:0]      rsp_moves_q;
  logic            rsp_oob_q;

  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = cand[ID_W-1:0];
      if (!found && req_i[cand_idx]) begin
        found   = 1'b1;
        gnt_idx = cand_idx;
      end
    end
`ifdef PACMAN_PRIORITY_EN
    if (req_i[0]) begin
      found   = 1'b1;
      gnt_idx = '0;
    end
`endif
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef PACMAN_PRIORITY_EN
    if (req_i[0]) ptr_d = ptr_q;
`endif
  end

  // Coordinate mux and address arithmetic for the winning requester.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_x = req_x_i[3*i +: 3];
        sel_y = req_y_i[3*i +: 3];
      end
    end
    oob       = (int'(sel_x) >= GRID_W) || (int'(sel_y) >= GRID_H);
    addr_full = int'(sel_y) * GRID_W + int'(sel_x);
    addr_d    = oob ? 6'd0 : addr_full[5:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= '0;
      s1_oob_q    <= 1'b0;
      tbl_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_moves_q <= '0;
      rsp_oob_q   <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      s1_valid_q <= found;
      if (found) begin
        s1_id_q    <= gnt_idx;
        s1_oob_q   <= oob;
        tbl_addr_q <= addr_d;
      end
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_q    <= s1_id_q;
        rsp_oob_q   <= s1_oob_q;
        rsp_moves_q <= s1_oob_q ? 4'b0000 : tbl_data_i;
      end
    end
  end

  // Grant is masked during reset so every output reads zero while rst_n is low.
  assign gnt_o       = (found && rst_n) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign tbl_addr_o  = tbl_addr_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_moves_o = rsp_moves_q;
  assign rsp_oob_o   = rsp_oob_q;
  assign dbg_ptr_o   = ptr_q;

endmodule

// File: doc/legal_move_arbiter.md
Name: legal_move_arbiter

Overview:
- Shares the single-ported legal-move table (8x8 tiles, 4 bits per tile) between Pacman and the ghost movers.
- Each requester presents a tile coordinate. The arbiter grants one requester per cycle and drives the table address.
- It returns that tile's legal-move nibble, tagged with the requester ID, two cycles after the grant.
- Sits between the movement FSMs and the legal-move table.

Parameters:
- NUM_REQ, 5, number of requesters; index 0 = Pacman, 1..4 = ghosts.
- GRID_W, 8, tiles per row.
- GRID_H, 8, tiles per column.
- ID_W, 3, width of requester ID; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request level.
- req_x  input  NUM_REQ*3  packed tile x per requester; requester i occupies bits [3i+2:3i].
- req_y  input  NUM_REQ*3  packed tile y per requester, same packing.
- gnt  output  NUM_REQ  one-hot grant pulse, combinational from req and the arbitration state.
- tbl_addr  output  6  registered table address = y*GRID_W + x, row-major, (0,0) = top-left.
- tbl_data  input  4  table read data, combinational from tbl_addr; bit3 = left, bit2 = right, bit1 = up, bit0 = down.
- rsp_valid  output  1  response strobe, one cycle per grant.
- rsp_id  output  ID_W  index of the requester the response belongs to.
- rsp_moves  output  4  legal-move nibble, same bit order as tbl_data.
- rsp_oob  output  1  the requested coordinate was outside the grid.

Behaviour:
- Reset values (async, rst_n = 0): gnt = 0, tbl_addr = 0, rsp_valid = 0, rsp_id = 0, rsp_moves = 0, rsp_oob = 0.
- Reset also clears the round-robin pointer to 0 and both pipeline valid bits.
- Handshake:
  - Requester raises req[i] and holds req_x/req_y stable until it sees gnt[i] = 1 in the same cycle.
  - Coordinates are sampled on the edge that ends the gnt[i] cycle.
  - If req[i] is still high in the following cycle, that is a new request.
- Arbitration:
  - Round-robin over the asserted req bits.
  - Search starts at the pointer and wraps from NUM_REQ-1 to 0.
  - On a grant to index k, the pointer becomes (k+1) mod NUM_REQ.
  - With no request asserted, gnt = 0 and the pointer holds.
  - At most one gnt bit is high per cycle.
- Pipeline (cycle G = grant cycle):
  - Edge ending G: stage-1 register captures valid, ID, oob flag, and tbl_addr.
  - Cycle G+1: tbl_data is valid.
  - Edge ending G+1: stage-2 register captures the response.
  - rsp_valid = 1 during cycle G+2.
  - Latency from grant to response is 2 cycles; throughput is one response per cycle.
  - Responses return in grant order. No backpressure: the consumer must accept rsp_valid when it is high.
- Out of bounds:
  - The condition is x >= GRID_W or y >= GRID_H (possible with 3-bit fields when GRID_W or GRID_H < 8).
  - tbl_addr is forced to 0, rsp_oob = 1 and rsp_moves = 4'b0000, whatever tbl_data returns.
- Address arithmetic: y*GRID_W + x is computed at full width, then truncated to 6 bits. Valid only for in-grid coordinates.
- Idle cycles: tbl_addr holds its last value.
- Reset mid-operation: in-flight lookups are discarded, and no rsp_valid is issued for them after rst_n rises.
- The first cycle after reset release may grant.
- Simultaneous events: a requester whose gnt pulses in the same cycle as its earlier response's rsp_valid is legal; both proceed independently.

Optional Feature:
- Macro: PACMAN_PRIORITY_EN.
- Defined:
  - Requester 0 wins whenever req[0] = 1, regardless of the pointer.
  - A grant to 0 leaves the pointer unchanged.
  - Requesters 1..NUM_REQ-1 round-robin among themselves only when req[0] = 0.
- Undefined: plain round-robin over all NUM_REQ requesters, as described in Behaviour.

Test Plan:
- Single lookup:
  - Stimulus: reset, then req = 5'b00001 with x = 1, y = 1; table model returns 4'b0101 at address 9.
  - Response: gnt = 5'b00001 in cycle 0; tbl_addr = 9 in cycle 1; rsp_valid = 1, rsp_id = 0, rsp_moves = 4'b0101, rsp_oob = 0 in cycle 2.
- Full contention:
  - Stimulus: req = 5'b11111 held for 10 cycles.
  - Response: grants go 0,1,2,3,4,0,1,2,3,4; responses arrive in the same order 2 cycles later, with no gaps.
- Wrap and skip:
  - Stimulus: pointer at 3 (after a grant to 2), then req = 5'b00011.
  - Response: grant to 0, then pointer = 1, so the next grant is to 1.
- Out of bounds:
  - Stimulus: GRID_W = 6, request x = 7, y = 0.
  - Response: rsp_oob = 1, rsp_moves = 4'b0000, tbl_addr = 0.
- Reset mid-flight:
  - Stimulus: assert rst_n = 0 one cycle after a grant.
  - Response: all outputs go to 0 immediately, and no rsp_valid appears after release.
- PACMAN_PRIORITY_EN defined, req = 5'b11111 for 4 cycles:
  - With req[0] held high: all 4 grants go to 0.
  - With req[0] dropped: grants go 1,2,3,4.
